fma_result_wb: RTL and testbench
================================

Name: fma_result_wb

Overview:
- Writeback and retire stage directly downstream of the FMA normalise/round stage.
- Captures the rounded sign, exponent, mantissa and the four IEEE exception flags, packs them into a binary32 word, and passes it with its destination tag through a 2-entry skid buffer using a valid/ready handshake.
- Maintains the sticky accumulated fflags register (RISC-V NV/DZ/OF/UF/NX) that the CSR file reads and writes.

Parameters:
- PARM_EXP, 8, exponent width
- PARM_MANT, 23, stored mantissa width
- PARM_TAG, 5, destination register tag width
- PARM_XLEN, PARM_EXP+PARM_MANT+1, packed result width (derived; not overridden)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- Valid_i  in  1  upstream result valid
- Ready_o  out  1  stage can accept
- Sign_result_i  in  1  rounded sign
- Exp_result_i  in  PARM_EXP  rounded biased exponent
- Mant_result_i  in  PARM_MANT  rounded mantissa
- Tag_i  in  PARM_TAG  destination tag
- Invalid_i, Overflow_i, Underflow_i, Inexact_i  in  1 each  exception flags of this result
- Valid_o  out  1  result valid to register file
- Ready_i  in  1  register file accepts
- Result_o  out  PARM_XLEN  {sign, exp, mant}
- Tag_o  out  PARM_TAG  destination tag
- Fflags_o  out  5  per-result flags {NV,DZ,OF,UF,NX}; DZ is always 0
- Fflags_clr_i  in  1  clear accumulated flags
- Fflags_wr_i  in  1  CSR write of accumulated flags
- Fflags_wdata_i  in  5  CSR write data
- Fflags_acc_o  out  5  accumulated sticky flags

Behaviour:
- Clock is clk_i. Reset rst_i is asynchronous, active-high.
- Reset values: Valid_o=0, Ready_o=1, Result_o=0, Tag_o=0, Fflags_o=0, Fflags_acc_o=0. Both buffer entries are empty.
- Accept: Valid_i && Ready_o.
- Retire: Valid_o && Ready_i.
- Storage:
  - Main register M drives the outputs.
  - Skid register S holds one overflow entry.
  - Ready_o = !S_full; it is registered, with no combinational path from Ready_i.
- Latency: an accepted result appears on the outputs 1 cycle later when M is empty or retiring that cycle. Throughput is 1 per cycle while Ready_i stays high.
- Buffer state machine (EMPTY, ONE, FULL):
  - EMPTY: accept -> ONE (load M).
  - ONE, accept and retire -> ONE (load M).
  - ONE, accept only -> FULL (load S).
  - ONE, retire only -> EMPTY.
  - FULL: Ready_o=0. Retire -> ONE (S moves into M).
- Ordering is strictly FIFO. Valid_i while Ready_o=0 is ignored; upstream holds its data.
- Packing: Result_o = {Sign, Exp, Mant}. Fflags_o = {Invalid, 1'b0, Overflow, Underflow, Inexact}. Each entry stores its own flags.
- Accumulated flags are updated every cycle with base = Fflags_clr_i ? 0 : Fflags_wr_i ? Fflags_wdata_i : acc.
  - New acc = base | (retire ? Fflags_o : 0).
  - Clear has priority over write.
  - Flags of a result retiring in the same cycle are never lost.
- Accumulation happens at retire, not at accept.
- Reset asserted mid-operation discards buffered entries and zeroes acc immediately.
- Output data must hold stable while Valid_o=1 and Ready_i=0.

Optional Feature:
- Macro FMA_WB_PERF_CNT_EN.
- When defined:
  - Adds outputs Retire_cnt_o[31:0] and Inexact_cnt_o[31:0].
  - Both reset to 0.
  - Retire_cnt_o increments on each retire.
  - Inexact_cnt_o increments on each retire with NX=1.
  - Both wrap modulo 2^32.
  - Both clear on Fflags_clr_i.
  - When a retire and a clear coincide, the counters load the retire's contribution (1 or 0).
- When undefined: the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package fma_pkg holds:
  - fflags bit index constants: FFLAG_NV=4, FFLAG_DZ=3, FFLAG_OF=2, FFLAG_UF=1, FFLAG_NX=0.
  - A packed struct typedef for a buffer entry {tag, result, flags}.
  - Default widths EXP=8, MANT=23, TAG=5.
- One sub-module, fma_wb_skid, is the generic 2-entry skid buffer parameterised on entry width.
- Fflags accumulation and the perf counters stay in the top module.

Test Plan:
- Reset, then a single result {Sign=0, Exp=8'h7F, Mant=0, Tag=3, NX=1} with Ready_i=1:
  - Valid_o rises 1 cycle later.
  - Result_o=32'h3F800000, Tag_o=3, Fflags_o=5'b00001.
  - Fflags_acc_o=5'b00001 the cycle after retire.
- Ready_i=0 while 3 results with tags 1, 2, 3 are offered back-to-back:
  - Tags 1 and 2 are accepted.
  - Ready_o=0 from the cycle after the second accept; tag 3 is held.
  - On Ready_i=1, outputs are 1, 2, 3 in order with no loss or duplication.
- Streaming with Ready_i toggling every cycle over 20 random results: output order and data match a scoreboard exactly.
- Result with OF=1, NX=1 retiring in the same cycle as Fflags_wr_i=1, Fflags_wdata_i=5'b10000: Fflags_acc_o=5'b10101.
- Fflags_clr_i pulse in the same cycle as a retire with NV=1: Fflags_acc_o=5'b10000.
- rst_i asserted asynchronously while FULL: Valid_o=0, Ready_o=1 and Fflags_acc_o=0 immediately, before any clock edge. With FMA_WB_PERF_CNT_EN defined, counters read 0 and Inexact_cnt_o=2 after two NX retires.

Source files
------------

// File: rtl/fma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fma_pkg
// Description : Shared definitions for the FMA writeback stage. Holds the
//               RISC-V fflags bit positions, default field widths, the
//               buffer-entry layout and a helper that packs the four IEEE
//               exception flags into fflags order.
// Revision    : 1.0 - initial release
// ============================================================================
package fma_pkg;

    // Default binary32 field widths
    localparam int EXP  = 8;
    localparam int MANT = 23;
    localparam int TAG  = 5;

    // fflags bit positions {NV, DZ, OF, UF, NX}
    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    // One buffered writeback entry, most significant field first
    typedef struct packed {
        logic [TAG-1:0]    tag;
        logic [EXP+MANT:0] result;
        logic [4:0]        flags;
    } fma_wb_entry_t;

    // An FMA never divides, so DZ is always zero
    function automatic logic [4:0] pack_fflags(input logic nv, input logic of,
                                               input logic uf, input logic nx);
        logic [4:0] f;
        f           = '0;
        f[FFLAG_NV] = nv;
        f[FFLAG_DZ] = 1'b0;
        f[FFLAG_OF] = of;
        f[FFLAG_UF] = uf;
        f[FFLAG_NX] = nx;
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fma_wb_skid.sv
`default_nettype none
// ============================================================================
// Module      : fma_wb_skid
// Description : Generic 2-entry skid buffer with valid/ready handshake.
//               Main register drives the outputs; the skid register absorbs
//               one entry when the consumer stalls. o_ready is registered
//               (no combinational path from i_ready). Strict FIFO order.
// Ports       : clk, rst (async, active-high)
//               i_valid / o_ready / i_data   - upstream side
//               o_valid / i_ready / o_data   - downstream side
// Revision    : 1.0 - initial release
// ============================================================================
module fma_wb_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_valid;
    logic             r_ready;

    logic w_accept;
    logic w_retire;

    assign w_accept = i_valid & r_ready;
    assign w_retire = r_valid & i_ready;

    // Valid and ready are kept as registers alongside the state so both
    // outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) begin
                        r_main  <= i_data;
                        r_valid <= 1'b1;
                        r_state <= c_ST_ONE;
                    end
                end
                c_ST_ONE: begin
                    if (w_accept && w_retire) begin
                        r_main <= i_data;
                    end else if (w_accept) begin
                        r_skid  <= i_data;
                        r_ready <= 1'b0;
                        r_state <= c_ST_FULL;
                    end else if (w_retire) begin
                        r_valid <= 1'b0;
                        r_state <= c_ST_EMPTY;
                    end
                end
                c_ST_FULL: begin
                    // r_ready is low here, so no accept can coincide
                    if (w_retire) begin
                        r_main  <= r_skid;
                        r_ready <= 1'b1;
                        r_state <= c_ST_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_data  = r_main;

endmodule

`default_nettype wire

// File: rtl/fma_result_wb.sv
`default_nettype none
// ============================================================================
// Module      : fma_result_wb
// Description : FMA writeback/retire stage. Packs the rounded sign, exponent
//               and mantissa into a binary32 word with its per-result fflags,
//               passes it with its destination tag through a 2-entry skid
//               buffer, and maintains the sticky accumulated fflags register.
// Ports       : clk_i, rst_i (async, active-high)
//               Valid_i/Ready_o, Sign/Exp/Mant_result_i, Tag_i, flag inputs
//               Valid_o/Ready_i, Result_o, Tag_o, Fflags_o
//               Fflags_clr_i, Fflags_wr_i, Fflags_wdata_i, Fflags_acc_o
// Options     : FMA_WB_PERF_CNT_EN adds Retire_cnt_o and Inexact_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
module fma_result_wb
    import fma_pkg::*;
#(
    parameter  int PARM_EXP  = EXP,
    parameter  int PARM_MANT = MANT,
    parameter  int PARM_TAG  = TAG,
    localparam int PARM_XLEN = PARM_EXP + PARM_MANT + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 Valid_i,
    output logic                 Ready_o,
    input  logic                 Sign_result_i,
    input  logic [PARM_EXP-1:0]  Exp_result_i,
    input  logic [PARM_MANT-1:0] Mant_result_i,
    input  logic [PARM_TAG-1:0]  Tag_i,
    input  logic                 Invalid_i,
    input  logic                 Overflow_i,
    input  logic                 Underflow_i,
    input  logic                 Inexact_i,
    output logic                 Valid_o,
    input  logic                 Ready_i,
    output logic [PARM_XLEN-1:0] Result_o,
    output logic [PARM_TAG-1:0]  Tag_o,
    output logic [4:0]           Fflags_o,
    input  logic                 Fflags_clr_i,
    input  logic                 Fflags_wr_i,
    input  logic [4:0]           Fflags_wdata_i,
    output logic [4:0]           Fflags_acc_o
`ifdef FMA_WB_PERF_CNT_EN
    ,
    output logic [31:0]          Retire_cnt_o,
    output logic [31:0]          Inexact_cnt_o
`endif
);

    localparam int c_ENTRY_W = PARM_TAG + PARM_XLEN + 5;

    logic [c_ENTRY_W-1:0] w_in_entry;
    logic [c_ENTRY_W-1:0] w_out_entry;
    logic                 w_retire;
    logic [4:0]           w_acc_base;
    logic [4:0]           r_acc;

    // Each entry carries its own flags so they retire with their result
    assign w_in_entry = {Tag_i, Sign_result_i, Exp_result_i, Mant_result_i,
                         pack_fflags(Invalid_i, Overflow_i, Underflow_i, Inexact_i)};

    fma_wb_skid #(
        .WIDTH (c_ENTRY_W)
    ) u_skid (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_valid (Valid_i),
        .o_ready (Ready_o),
        .i_data  (w_in_entry),
        .o_valid (Valid_o),
        .i_ready (Ready_i),
        .o_data  (w_out_entry)
    );

    assign {Tag_o, Result_o, Fflags_o} = w_out_entry;
    assign w_retire = Valid_o & Ready_i;

    // Clear beats CSR write; retiring flags are OR-ed on top of either so a
    // result retiring alongside a CSR access never loses its flags.
    always_comb begin
        w_acc_base = r_acc;
        if (Fflags_clr_i) begin
            w_acc_base = '0;
        end else if (Fflags_wr_i) begin
            w_acc_base = Fflags_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_base | (w_retire ? Fflags_o : 5'b0);
        end
    end

    assign Fflags_acc_o = r_acc;

`ifdef FMA_WB_PERF_CNT_EN
    logic [31:0] r_retire_cnt;
    logic [31:0] r_inexact_cnt;
    logic        w_nx_retire;

    assign w_nx_retire = w_retire & Fflags_o[FFLAG_NX];

    // On a clear the counters restart from this cycle's contribution
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_retire_cnt  <= '0;
            r_inexact_cnt <= '0;
        end else if (Fflags_clr_i) begin
            r_retire_cnt  <= {31'b0, w_retire};
            r_inexact_cnt <= {31'b0, w_nx_retire};
        end else begin
            r_retire_cnt  <= r_retire_cnt + {31'b0, w_retire};
            r_inexact_cnt <= r_inexact_cnt + {31'b0, w_nx_retire};
        end
    end

    assign Retire_cnt_o  = r_retire_cnt;
    assign Inexact_cnt_o = r_inexact_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fma_result_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fma_result_wb
// Description : Self-checking bench for fma_result_wb with directed vectors
//               and a FIFO scoreboard for the handshake scenarios.
// Options     : FMA_WB_PERF_CNT_EN enables the performance counter checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fma_result_wb;
    import fma_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        Valid_i;
    logic        Ready_o;
    logic        Sign_result_i;
    logic [7:0]  Exp_result_i;
    logic [22:0] Mant_result_i;
    logic [4:0]  Tag_i;
    logic        Invalid_i, Overflow_i, Underflow_i, Inexact_i;
    logic        Valid_o;
    logic        Ready_i;
    logic [31:0] Result_o;
    logic [4:0]  Tag_o;
    logic [4:0]  Fflags_o;
    logic        Fflags_clr_i;
    logic        Fflags_wr_i;
    logic [4:0]  Fflags_wdata_i;
    logic [4:0]  Fflags_acc_o;
`ifdef FMA_WB_PERF_CNT_EN
    logic [31:0] Retire_cnt_o;
    logic [31:0] Inexact_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    fma_result_wb dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .Valid_i        (Valid_i),
        .Ready_o        (Ready_o),
        .Sign_result_i  (Sign_result_i),
        .Exp_result_i   (Exp_result_i),
        .Mant_result_i  (Mant_result_i),
        .Tag_i          (Tag_i),
        .Invalid_i      (Invalid_i),
        .Overflow_i     (Overflow_i),
        .Underflow_i    (Underflow_i),
        .Inexact_i      (Inexact_i),
        .Valid_o        (Valid_o),
        .Ready_i        (Ready_i),
        .Result_o       (Result_o),
        .Tag_o          (Tag_o),
        .Fflags_o       (Fflags_o),
        .Fflags_clr_i   (Fflags_clr_i),
        .Fflags_wr_i    (Fflags_wr_i),
        .Fflags_wdata_i (Fflags_wdata_i),
        .Fflags_acc_o   (Fflags_acc_o)
`ifdef FMA_WB_PERF_CNT_EN
        ,
        .Retire_cnt_o   (Retire_cnt_o),
        .Inexact_cnt_o  (Inexact_cnt_o)
`endif
    );

    // Expected {tag, result, flags} word built from the input fields
    function automatic fma_wb_entry_t make_word(input logic [4:0] t, input logic s,
                                                input logic [7:0] e, input logic [22:0] m,
                                                input logic nv, input logic of,
                                                input logic uf, input logic nx);
        fma_wb_entry_t w;
        w.tag    = t;
        w.result = {s, e, m};
        w.flags  = {nv, 1'b0, of, uf, nx};
        return w;
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_result(input logic s, input logic [7:0] e, input logic [22:0] m,
                                input logic [4:0] t, input logic nv, input logic of,
                                input logic uf, input logic nx);
        Valid_i       = 1'b1;
        Sign_result_i = s;
        Exp_result_i  = e;
        Mant_result_i = m;
        Tag_i         = t;
        Invalid_i     = nv;
        Overflow_i    = of;
        Underflow_i   = uf;
        Inexact_i     = nx;
    endtask

    task automatic test_reset;
        rst_i          = 1'b1;
        Valid_i        = 1'b0;
        Ready_i        = 1'b0;
        Fflags_clr_i   = 1'b0;
        Fflags_wr_i    = 1'b0;
        Fflags_wdata_i = 5'b0;
        drive_result(1'b0, 8'h00, 23'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        Valid_i = 1'b0;
        tick;
        tick;
        checks++; if (Valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Valid_o); end
        checks++; if (Ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", Ready_o); end
        checks++; if (Result_o !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", Result_o); end
        checks++; if (Tag_o !== 5'd0) begin failures++; $display("FAIL reset_tag got=%0d exp=0", Tag_o); end
        checks++; if (Fflags_o !== 5'b0) begin failures++; $display("FAIL reset_fflags got=%b exp=0", Fflags_o); end
        checks++; if (Fflags_acc_o !== 5'b0) begin failures++; $display("FAIL reset_acc got=%b exp=0", Fflags_acc_o); end
        rst_i = 1'b0;
        tick;
    endtask

    task automatic test_single;
        Ready_i = 1'b1;
        drive_result(1'b0, 8'h7F, 23'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (Valid_o !== 1'b0) begin failures++; $display("FAIL single_pre_valid got=%b exp=0", Valid_o); end
        tick;
        Valid_i = 1'b0;
        checks++; if (Valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", Valid_o); end
        checks++; if (Result_o !== 32'h3F800000) begin failures++; $display("FAIL single_result got=%h exp=3f800000", Result_o); end
        checks++; if (Tag_o !== 5'd3) begin failures++; $display("FAIL single_tag got=%0d exp=3", Tag_o); end
        checks++; if (Fflags_o !== 5'b00001) begin failures++; $display("FAIL single_fflags got=%b exp=00001", Fflags_o); end
        checks++; if (Fflags_acc_o !== 5'b00000) begin failures++; $display("FAIL single_acc_early got=%b exp=00000", Fflags_acc_o); end
        tick;
        checks++; if (Valid_o !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", Valid_o); end
        checks++; if (Fflags_acc_o !== 5'b00001) begin failures++; $display("FAIL single_acc got=%b exp=00001", Fflags_acc_o); end
        Fflags_clr_i = 1'b1;
        tick;
        Fflags_clr_i = 1'b0;
        checks++; if (Fflags_acc_o !== 5'b00000) begin failures++; $display("FAIL clear_acc got=%b exp=00000", Fflags_acc_o); end
    endtask

    task automatic test_back_to_back;
        logic [4:0] exp_tags[$];
        logic [4:0] et;
        logic       acc_now;
        int         sent = 0;
        int         got  = 0;
        Ready_i = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
            if (cyc == 6) Ready_i = 1'b1;
            if (sent < 3) drive_result(1'b0, 8'h80, 23'(sent + 1), 5'(sent + 1), 1'b0, 1'b0, 1'b0, 1'b0);
            else Valid_i = 1'b0;
            acc_now = Valid_i && Ready_o;
            if (Valid_o && Ready_i) begin
                checks++;
                if (exp_tags.size() == 0) begin
                    failures++; $display("FAIL b2b_extra got_tag=%0d exp=none", Tag_o);
                end else begin
                    et = exp_tags.pop_front();
                    if (Tag_o !== et || Result_o !== {1'b0, 8'h80, 18'h0, et}) begin
                        failures++; $display("FAIL b2b_order got_tag=%0d res=%h exp_tag=%0d", Tag_o, Result_o, et);
                    end
                end
                got++;
            end
            if (acc_now) exp_tags.push_back(5'(sent + 1));
            tick;
            if (acc_now) begin
                sent++;
                if (sent == 2) begin
                    checks++; if (Ready_o !== 1'b0) begin failures++; $display("FAIL b2b_full_ready got=%b exp=0", Ready_o); end
                end
            end
            if (cyc == 5) begin
                checks++; if (Tag_o !== 5'd1 || Valid_o !== 1'b1) begin failures++; $display("FAIL b2b_hold got_tag=%0d valid=%b exp_tag=1 valid=1", Tag_o, Valid_o); end
                checks++; if (sent !== 2) begin failures++; $display("FAIL b2b_tag3_held got_sent=%0d exp=2", sent); end
            end
        end
        Valid_i = 1'b0;
        checks++; if (got !== 3 || exp_tags.size() !== 0) begin failures++; $display("FAIL b2b_count got=%0d left=%0d exp=3,0", got, exp_tags.size()); end
        tick;
        checks++; if (Valid_o !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", Valid_o); end
    endtask

    task automatic test_stream;
        fma_wb_entry_t exp_q[$];
        fma_wb_entry_t vec[20];
        fma_wb_entry_t ew;
        logic [31:0]   r;
        logic          acc_now;
        int            sent = 0;
        int            got  = 0;
        int            bad  = 0;
        for (int i = 0; i < 20; i++) begin
            r = $urandom;
            vec[i] = make_word(5'(i + 7), r[31], r[30:23], r[22:0], r[3], r[2], r[1], r[0]);
            if (i == 4) vec[i] = make_word(5'd11, 1'b1, 8'hFF, 23'h1, 1'b1, 1'b1, 1'b1, 1'b1);
        end
        for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
            Ready_i = cyc[0];
            if (sent < 20) begin
                ew = vec[sent];
                drive_result(ew.result[31], ew.result[30:23], ew.result[22:0], ew.tag,
                             ew.flags[4], ew.flags[2], ew.flags[1], ew.flags[0]);
            end else begin
                Valid_i = 1'b0;
            end
            acc_now = Valid_i && Ready_o;
            if (Valid_o && Ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; bad++; $display("FAIL stream_extra got=%h exp=none", {Tag_o, Result_o, Fflags_o});
                end else begin
                    ew = exp_q.pop_front();
                    if ({Tag_o, Result_o, Fflags_o} !== ew) begin
                        failures++; bad++; $display("FAIL stream_data got=%h exp=%h", {Tag_o, Result_o, Fflags_o}, ew);
                    end
                end
                got++;
            end
            if (acc_now) exp_q.push_back(vec[sent]);
            tick;
            if (acc_now) sent++;
        end
        Valid_i = 1'b0;
        Ready_i = 1'b1;
        checks++; if (got !== 20 || exp_q.size() !== 0) begin failures++; $display("FAIL stream_count got=%0d left=%0d exp=20,0", got, exp_q.size()); end
        tick;
        tick;
    endtask

    task automatic test_fflags_write;
        Fflags_clr_i = 1'b1;
        tick;
        Fflags_clr_i = 1'b0;
        Ready_i = 1'b0;
        drive_result(1'b0, 8'hFE, 23'h7FFFFF, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1);
        tick;
        Valid_i = 1'b0;
        checks++; if (Fflags_o !== 5'b00101) begin failures++; $display("FAIL wr_fflags got=%b exp=00101", Fflags_o); end
        Ready_i        = 1'b1;
        Fflags_wr_i    = 1'b1;
        Fflags_wdata_i = 5'b10000;
        tick;
        Fflags_wr_i    = 1'b0;
        Fflags_wdata_i = 5'b0;
        checks++; if (Fflags_acc_o !== 5'b10101) begin failures++; $display("FAIL wr_acc got=%b exp=10101", Fflags_acc_o); end
    endtask

    task automatic test_fflags_clear;
        Ready_i = 1'b0;
        drive_result(1'b1, 8'hFF, 23'h400000, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        tick;
        Valid_i = 1'b0;
        checks++; if (Fflags_o !== 5'b10000) begin failures++; $display("FAIL clr_fflags got=%b exp=10000", Fflags_o); end
        Ready_i      = 1'b1;
        Fflags_clr_i = 1'b1;
        tick;
        Fflags_clr_i = 1'b0;
        checks++; if (Fflags_acc_o !== 5'b10000) begin failures++; $display("FAIL clr_acc got=%b exp=10000", Fflags_acc_o); end
    endtask

    task automatic test_async_reset;
        Ready_i = 1'b0;
        drive_result(1'b0, 8'h01, 23'h1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        tick;
        drive_result(1'b0, 8'h02, 23'h2, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1);
        tick;
        checks++; if (Ready_o !== 1'b0) begin failures++; $display("FAIL arst_pre_full got=%b exp=0", Ready_o); end
        #2;
        rst_i = 1'b1;
        #1;
        checks++; if (Valid_o !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", Valid_o); end
        checks++; if (Ready_o !== 1'b1) begin failures++; $display("FAIL arst_ready got=%b exp=1", Ready_o); end
        checks++; if (Fflags_acc_o !== 5'b0) begin failures++; $display("FAIL arst_acc got=%b exp=0", Fflags_acc_o); end
        checks++; if (Result_o !== 32'h0) begin failures++; $display("FAIL arst_result got=%h exp=0", Result_o); end
`ifdef FMA_WB_PERF_CNT_EN
        checks++; if (Retire_cnt_o !== 32'd0 || Inexact_cnt_o !== 32'd0) begin failures++; $display("FAIL arst_cnt got=%0d,%0d exp=0,0", Retire_cnt_o, Inexact_cnt_o); end
`endif
        Valid_i = 1'b0;
        tick;
        rst_i = 1'b0;
        tick;
    endtask

`ifdef FMA_WB_PERF_CNT_EN
    task automatic test_perf_cnt;
        Ready_i = 1'b1;
        drive_result(1'b0, 8'h10, 23'h3, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick;
        drive_result(1'b0, 8'h11, 23'h4, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        tick;
        Valid_i = 1'b0;
        tick;
        checks++; if (Inexact_cnt_o !== 32'd2) begin failures++; $display("FAIL perf_nx got=%0d exp=2", Inexact_cnt_o); end
        checks++; if (Retire_cnt_o !== 32'd2) begin failures++; $display("FAIL perf_ret got=%0d exp=2", Retire_cnt_o); end
        Ready_i = 1'b0;
        drive_result(1'b0, 8'h12, 23'h5, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        Valid_i      = 1'b0;
        Ready_i      = 1'b1;
        Fflags_clr_i = 1'b1;
        tick;
        Fflags_clr_i = 1'b0;
        checks++; if (Retire_cnt_o !== 32'd1 || Inexact_cnt_o !== 32'd0) begin failures++; $display("FAIL perf_clr got=%0d,%0d exp=1,0", Retire_cnt_o, Inexact_cnt_o); end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_stream;
        test_fflags_write;
        test_fflags_clear;
        test_async_reset;
`ifdef FMA_WB_PERF_CNT_EN
        test_perf_cnt;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
